// File: rtl/pager_if.sv
// Serial receive link between the bit slicer and the page detector.
// x is the sliced receive bit, z is the page alert back to the beeper/LED.
interface pager_if;
    logic x;
    logic z;

    // Bit slicer side: supplies bits, observes the alert.
    modport master (output x, input z);
    // Detector side: consumes bits, drives the alert.
    modport slave  (input x, output z);
endinterface

// File: rtl/pager_alert_timer.sv
// Loadable down-counter that holds the alert high for ALERT_LEN cycles.
// A load while already counting restarts the full interval, so back-to-back
// matches stretch one pulse instead of producing two.
module pager_alert_timer #(
    parameter int ALERT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active
);
    localparam int CW = $clog2(ALERT_LEN + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next count: reload on match, otherwise drain toward zero.
    always_comb begin
        cnt_nxt = cnt;
        if (load)
            cnt_nxt = CW'(ALERT_LEN);
        else if (cnt != '0)
            cnt_nxt = cnt - CW'(1);
    end

    // Count and alert flag are both registered, so active is a clean flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            active <= (cnt_nxt != '0);
        end
    end
endmodule

// File: rtl/pager.sv
// Serial page-word detector. Shifts in one bit per clock, compares the
// newest PAT_LEN bits (oldest in the MSB) with PATTERN, and fires the alert
// timer on a hit. Detection overlaps: the last bit of one match may begin
// the next. The fill counter keeps bits from before reset release, and the
// zeros the history is cleared to, from ever forming a match.
module pager #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b0011,
    parameter int                 ALERT_LEN = 4
) (
    input  logic    clk,
    input  logic    rst,
    pager_if.slave  bus
);
    localparam int FW = $clog2(PAT_LEN + 1);

    // Only PAT_LEN-1 past bits are kept; the current x completes the window.
    logic [PAT_LEN-2:0] hist;
    logic [PAT_LEN-1:0] window;
    logic [FW-1:0]      fill;
    logic               match;

    assign window = {hist, bus.x};
    assign match  = (window == PATTERN) && (fill >= FW'(PAT_LEN - 1));

    // History shift and saturating count of bits seen since reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= window[PAT_LEN-2:0];
            if (fill != FW'(PAT_LEN))
                fill <= fill + FW'(1);
        end
    end

    pager_alert_timer #(
        .ALERT_LEN (ALERT_LEN)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (match),
        .active (bus.z)
    );
endmodule

// File: tb/tb_pager.sv
// Bench for pager: directed page-word scenarios followed by random bits and
// random resets, all checked against a queue-based model of the last PAT_LEN
// bits received since reset release plus a remaining-alert-cycles counter.
module tb_pager;
    localparam int               PAT_LEN   = 4;
    localparam logic [PAT_LEN-1:0] PATTERN = 4'b0011;
    localparam int               ALERT_LEN = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   hi_cnt;

    // Reference model state
    bit   q[$];
    int   m_left;

    pager_if intf ();

    pager #(
        .PAT_LEN   (PAT_LEN),
        .PATTERN   (PATTERN),
        .ALERT_LEN (ALERT_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a match is the last PAT_LEN post-reset bits equal to PATTERN.
    task automatic model_bit(input bit b);
        logic [PAT_LEN-1:0] w;
        q.push_back(b);
        if (q.size() > PAT_LEN) void'(q.pop_front());
        w = '0;
        foreach (q[i]) w = {w[PAT_LEN-2:0], q[i]};
        if (q.size() == PAT_LEN && w == PATTERN) m_left = ALERT_LEN;
        else if (m_left > 0) m_left--;
    endtask

    task automatic model_reset();
        q.delete();
        m_left = 0;
    endtask

    // Drive one bit ahead of the edge, then check z just after the edge.
    task automatic step(input bit b, input string tag);
        @(negedge clk);
        intf.x = b;
        @(posedge clk);
        #1;
        model_bit(b);
        chk(tag, {31'd0, intf.z}, (m_left > 0) ? 32'd1 : 32'd0);
        if (intf.z === 1'b1) hi_cnt++;
    endtask

    // Pulse reset low for one cycle; z must drop without waiting for an edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk(tag, {31'd0, intf.z}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive_seq(input logic [15:0] bits, input int n, input string tag);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(v[i], tag);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        hi_cnt = 0;
        model_reset();
        rst    = 1'b0;
        intf.x = 1'b1;

        // Reset held with x=1: z stays low throughout.
        #15 chk("rst_hold_a", {31'd0, intf.z}, 32'd0);
        #20 chk("rst_hold_b", {31'd0, intf.z}, 32'd0);
        #15 chk("rst_hold_c", {31'd0, intf.z}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Constant ones never page.
        hi_cnt = 0;
        for (int i = 0; i < 25; i++) step(1'b1, "idle_ones");
        chk("idle_ones_hi", hi_cnt, 0);

        // Page word then quiet: exactly ALERT_LEN high cycles.
        hi_cnt = 0;
        drive_seq(16'b0011, 4, "page");
        chk("page_rise", {31'd0, intf.z}, 32'd1);
        drive_seq(16'b000000, 6, "page_tail");
        chk("page_len", hi_cnt, ALERT_LEN);

        // Near miss: no 0011 substring anywhere.
        hi_cnt = 0;
        drive_seq(16'b0001001000, 10, "near_miss");
        chk("near_miss_hi", hi_cnt, 0);

        // Overlap/retrigger: two matches 4 apart give one 8-cycle pulse.
        hi_cnt = 0;
        drive_seq(16'b00110011, 8, "overlap");
        drive_seq(16'b000000, 6, "overlap_tail");
        chk("overlap_len", hi_cnt, 8);

        // Reset mid-alert, then 1,1 must not complete the earlier 0,0.
        drive_seq(16'b0011, 4, "pre_rst");
        chk("pre_rst_hi", {31'd0, intf.z}, 32'd1);
        pulse_reset("rst_mid_alert");
        hi_cnt = 0;
        drive_seq(16'b11, 2, "post_rst");
        chk("post_rst_hi", hi_cnt, 0);

        // Start-up fill: cleared history zeros must not pair with 1,1.
        pulse_reset("rst_fill");
        hi_cnt = 0;
        drive_seq(16'b11, 2, "fill");
        chk("fill_hi", hi_cnt, 0);

        // Random bits with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset("rand_rst");
            else step(1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
